pe_stream_reducer: RTL and testbench
====================================

PE_STREAM_REDUCER -- requirements
Module: pe_stream_reducer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: payload width; token width is DATA_WIDTH+1, bit DATA_WIDTH is the control flag.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clk_en  input  1  global clock enable; when low, no state changes.
REQ-006 flush  input  1  synchronous clear, same effect as reset, one-cycle minimum.
REQ-007 tile_en  input  1  tile enable; when low, input ready and output valid are held low.
REQ-008 data_in  input  17  token stream from PE_onyx res.
REQ-009 data_in_valid  input  1  upstream valid.
REQ-010 data_in_ready  output  1  accept strobe to upstream.
REQ-011 data_out  output  17  reduced token stream toward glb_read.
REQ-012 data_out_valid  output  1  downstream valid.
REQ-013 data_out_ready  input  1  downstream ready.
REQ-014 done_seen  output  1  sticky; set when a done token is pushed, cleared by rst/flush.

Function
REQ-015 Token decode: bit16=0 data; bit16=1 and bits[9:8]=01 done (0x10100); bit16=1 and bits[9:8]=00 stop, level = bits[7:0]; any other control token is "other".
REQ-016 Input handshake fires when data_in_valid & data_in_ready; data_in_ready = tile_en & clk_en & ~flush & (free FIFO entries >= 2).
REQ-017 Data token: acc <= acc + data_in[15:0], modulo 2^16 wrap; nothing pushed.
REQ-018 Stop level 0: push {1'b0, acc} in same cycle; acc <= 0.
REQ-019 Stop level n>0: push {1'b0, acc} then {1'b1, 6'b0, 2'b00, n-1} in that order in same cycle (two writes); acc <= 0.
REQ-020 Empty segment (stop with acc==0, no data since last stop) pushes sum 0.
REQ-021 Done token: push 0x10100 unchanged; acc untouched; done_seen <= 1.
REQ-022 Other control token: pushed unchanged; acc untouched.
REQ-023 Latency: pushed token visible on data_out with data_out_valid one cycle after input handshake when FIFO was empty.
REQ-024 Output pops on data_out_valid & data_out_ready; push and pop in the same cycle both occur; data_out_valid = tile_en & (FIFO not empty).
REQ-025 FIFO ordering strictly preserved; no token dropped or duplicated under any ready/valid pattern.
REQ-026 Full: with fewer than 2 free entries, input stalls; data_out_valid unaffected.
REQ-027 clk_en low: no push, no pop, acc and pointers frozen; data_out held stable.
REQ-028 Reset or flush mid-segment discards acc and all buffered tokens.

Reset
REQ-029 On rst (async) or flush (sync): acc=0, FIFO read/write pointers=0, count=0, done_seen=0.
REQ-030 Output values under reset: data_in_ready=0, data_out_valid=0, data_out=0, done_seen=0.

Structure
REQ-031 Shared package pe_stream_pkg holds token-type enum (DATA, STOP, DONE, OTHER), DONE_TOKEN=17'h10100, control-flag bit index and stop-level field bounds.
REQ-032 One sub-module reduce_out_fifo: DEPTH-entry, dual-write-port (write0, write1 ordered), single-read FIFO with count output.
REQ-033 Top level holds decode, accumulator and push-control logic only; no combinational path from data_out_ready to data_in_ready except via FIFO count.

Verification
REQ-034 In: 3,4,5,0x10000,0x10100, out_ready=1 -> out: 0x00000C, 0x10100; done_seen=1.
REQ-035 In: 1,2,0x10000,3,0x10001,0x10100 -> out: 0x3, 0x3, 0x10000, 0x10100.
REQ-036 In: 0xFFFF,2,0x10000 -> out 0x0001 (wrap); then 0x10000 alone -> out 0x0000.
REQ-037 out_ready=0 for 10 cycles during 8-token segmented stream -> data_in_ready low once free<2, full output sequence matches scoreboard after release.
REQ-038 rst asserted asynchronously after 1,2 accepted, then 5,0x10000 -> out only 0x0005; flush gives same result.
REQ-039 clk_en=0 for 3 cycles mid-stream -> acc, FIFO and data_out unchanged; totals correct afterward.

Source files
------------

// File: rtl/pe_stream_pkg.sv
// Shared token definitions for the PE stream reducer: token classes, field
// positions inside a control token and the fixed done token.
package pe_stream_pkg;

    typedef enum logic [1:0] {
        DATA,
        STOP,
        DONE,
        OTHER
    } token_kind_e;

    localparam int CTRL_BIT  = 16;
    localparam int TYPE_MSB  = 9;
    localparam int TYPE_LSB  = 8;
    localparam int LEVEL_MSB = 7;
    localparam int LEVEL_LSB = 0;
    localparam int LEVEL_W   = LEVEL_MSB - LEVEL_LSB + 1;

    localparam logic [1:0]  TYPE_STOP  = 2'b00;
    localparam logic [1:0]  TYPE_DONE  = 2'b01;
    localparam logic [16:0] DONE_TOKEN = 17'h10100;

    function automatic token_kind_e decode_kind(input logic ctrl, input logic [1:0] ttype);
        if (!ctrl)                  return DATA;
        else if (ttype == TYPE_STOP) return STOP;
        else if (ttype == TYPE_DONE) return DONE;
        else                        return OTHER;
    endfunction

endpackage

// File: rtl/reduce_out_fifo.sv
// Output buffer with two ordered write ports (write1 lands after write0 in the
// same cycle) and one read port; the head reads as zero while empty.
module reduce_out_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr0_en,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [WIDTH-1:0] wr1_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr1_ptr;

    // write1 takes the slot after write0 only when write0 is also used
    assign wr1_ptr = wr_ptr + PW'(wr0_en);

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]  <= wr0_data;
        if (wr1_en) mem[wr1_ptr] <= wr1_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr0_en) + PW'(wr1_en);
            rd_ptr <= rd_ptr + PW'(rd_en);
            count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
        end
    end

    assign rd_data = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pe_stream_reducer.sv
// Sums data tokens per segment and emits the sum at each stop token, forwarding
// control tokens in order through a small output buffer.
module pe_stream_reducer
    import pe_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                flush,
    input  logic                tile_en,
    input  logic [DATA_WIDTH:0] data_in,
    input  logic                data_in_valid,
    output logic                data_in_ready,
    output logic [DATA_WIDTH:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                done_seen
);
    localparam int TW = DATA_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [CW-1:0]         fifo_count;
    logic [LEVEL_W-1:0]    level;
    logic [TW-1:0]         wr0_data;
    logic [TW-1:0]         wr1_data;
    logic                  wr0_en;
    logic                  wr1_en;
    logic                  fire;
    logic                  pop;
    logic                  done_set;
    token_kind_e           kind;

    // Handshakes: a token moves on a cycle where valid and ready are both high
    // at the rising edge; ready never depends on valid or on data_out_ready.
    assign level          = data_in[LEVEL_MSB:LEVEL_LSB];
    assign kind           = decode_kind(data_in[DATA_WIDTH], data_in[TYPE_MSB:TYPE_LSB]);
    assign data_in_ready  = ~rst & tile_en & clk_en & ~flush
                            & (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign fire           = data_in_valid & data_in_ready;
    assign data_out_valid = tile_en & (fifo_count != '0);
    assign pop            = data_out_valid & data_out_ready & clk_en & ~flush;

    always_comb begin
        acc_next = acc;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = data_in;
        wr1_data = '0;
        done_set = 1'b0;
        if (fire) begin
            unique case (kind)
                DATA: acc_next = acc + data_in[DATA_WIDTH-1:0];
                STOP: begin
                    wr0_en   = 1'b1;
                    wr0_data = {1'b0, acc};
                    acc_next = '0;
                    // a nested stop is re-emitted one level shallower
                    if (level != '0) begin
                        wr1_en                         = 1'b1;
                        wr1_data[DATA_WIDTH]           = 1'b1;
                        wr1_data[LEVEL_MSB:LEVEL_LSB]  = level - LEVEL_W'(1);
                    end
                end
                DONE: begin
                    wr0_en   = 1'b1;
                    done_set = 1'b1;
                end
                OTHER: wr0_en = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            done_seen <= 1'b0;
        end else if (flush) begin
            acc       <= '0;
            done_seen <= 1'b0;
        end else if (clk_en) begin
            acc <= acc_next;
            if (done_set) done_seen <= 1'b1;
        end
    end

    reduce_out_fifo #(
        .WIDTH (TW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .rd_data  (data_out),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_pe_stream_reducer.sv
// Scoreboard bench for pe_stream_reducer: directed segment cases, backpressure,
// reset/flush, clock-enable freeze and a randomized token stream.
module tb_pe_stream_reducer;
    import pe_stream_pkg::DONE_TOKEN;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        flush;
    logic        tile_en;
    logic [16:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [16:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        done_seen;

    logic [16:0] exp_q[$];
    int          n_cmp;
    int          n_fail;
    int          ready_mode;   // 0 always ready, 1 never ready, 2 random
    bit          model_on;
    bit          stall_seen;
    int unsigned model_acc;
    bit          model_done;

    pe_stream_reducer dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .flush          (flush),
        .tile_en        (tile_en),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .done_seen      (done_seen)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // downstream ready driver
    initial begin
        data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_out_ready = 1'b1;
                1:       data_out_ready = 1'b0;
                default: data_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: segment sums modulo 2^16, control tokens by class
    task automatic model_accept(input logic [16:0] tok);
        int unsigned lvl;
        if (!tok[16]) begin
            model_acc = (model_acc + int'(tok[15:0])) % 65536;
        end else if (tok[9:8] == 2'b00) begin
            lvl = int'(tok[7:0]);
            exp_q.push_back(17'(model_acc));
            if (lvl > 0) exp_q.push_back(17'h10000 + 17'(lvl - 1));
            model_acc = 0;
        end else if (tok[9:8] == 2'b01) begin
            exp_q.push_back(tok);
            model_done = 1'b1;
        end else begin
            exp_q.push_back(tok);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_acc  = 0;
        model_done = 1'b0;
    endtask

    // monitor: a pop happens at the next rising edge when these hold
    initial begin
        forever begin
            @(negedge clk);
            if (data_in_valid && !data_in_ready && data_out_valid && !data_out_ready)
                stall_seen = 1'b1;
            if (!rst && !flush && clk_en && data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected no token", data_out);
                end else begin
                    check("out_token", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_tok(input logic [16:0] tok);
        bit ok;
        ok            = 1'b0;
        data_in       = tok;
        data_in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = data_in_ready;
            if (ok && model_on) model_accept(tok);
            @(posedge clk);
            #1;
            if (ok) break;
        end
        data_in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: token %h not accepted, expected accept within 200 cycles", tok);
        end
    endtask

    task automatic drain();
        ready_mode = 0;
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_token(output logic [16:0] tok);
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5)      tok = {1'b0, 16'($urandom)};
        else if (r <= 7) tok = {1'b1, 6'($urandom), 2'b00, 8'($urandom_range(0, 3))};
        else if (r == 8) tok = DONE_TOKEN;
        else             tok = {1'b1, 6'($urandom), 2'($urandom_range(2, 3)), 8'($urandom)};
    endtask

    initial begin
        logic [16:0] tok;
        n_cmp = 0; n_fail = 0; ready_mode = 0; model_on = 1'b0; stall_seen = 1'b0;
        rst = 1'b1; flush = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
        data_in = '0; data_in_valid = 1'b0;
        model_clear();

        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(data_in_ready), 32'd0);
        check("rst_out_valid", 32'(data_out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_done_seen", 32'(done_seen), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // directed: simple segment then done
        exp_q.push_back(17'h0000C); exp_q.push_back(17'h10100);
        send_tok(17'h3); send_tok(17'h4); send_tok(17'h5);
        send_tok(17'h10000); send_tok(17'h10100);
        drain();
        check("done_seen_set", 32'(done_seen), 32'd1);

        // directed: nested stop re-emitted one level lower
        exp_q.push_back(17'h3); exp_q.push_back(17'h3);
        exp_q.push_back(17'h10000); exp_q.push_back(17'h10100);
        send_tok(17'h1); send_tok(17'h2); send_tok(17'h10000);
        send_tok(17'h3); send_tok(17'h10001); send_tok(17'h10100);
        drain();

        // directed: wraparound and empty segment
        exp_q.push_back(17'h00001); exp_q.push_back(17'h00000);
        send_tok(17'h0FFFF); send_tok(17'h2); send_tok(17'h10000);
        send_tok(17'h10000);
        drain();

        // async reset mid-segment
        exp_q.push_back(17'h00005);
        send_tok(17'h1); send_tok(17'h2);
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        @(negedge clk);
        check("rst_clears_done", 32'(done_seen), 32'd0);
        @(posedge clk); #1;
        send_tok(17'h5); send_tok(17'h10000);
        drain();

        // flush mid-segment
        exp_q.push_back(17'h00005);
        send_tok(17'h1); send_tok(17'h2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        send_tok(17'h5); send_tok(17'h10000);
        drain();

        // backpressure: downstream stalled 10 cycles during an 8-token stream
        model_on = 1'b1;
        model_clear();
        ready_mode = 1;
        @(posedge clk); #1;
        stall_seen = 1'b0;
        fork
            begin
                send_tok(17'h1); send_tok(17'h10000); send_tok(17'h2); send_tok(17'h10000);
                send_tok(17'h3); send_tok(17'h10001); send_tok(17'h4); send_tok(17'h10000);
            end
            begin
                repeat (10) @(posedge clk);
                ready_mode = 0;
            end
        join
        check("input_stalled_when_full", 32'(stall_seen), 32'd1);
        drain();

        // clock enable low freezes everything
        ready_mode = 1;
        send_tok(17'h7); send_tok(17'h10000); send_tok(17'ha);
        repeat (2) @(posedge clk);
        #1;
        clk_en = 1'b0;
        data_in = 17'h5; data_in_valid = 1'b1;
        ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("clken_in_ready", 32'(data_in_ready), 32'd0);
            check("clken_out_valid", 32'(data_out_valid), 32'd1);
            check("clken_data_out", 32'(data_out), 32'h7);
        end
        @(posedge clk); #1;
        clk_en = 1'b1;
        data_in_valid = 1'b0;
        send_tok(17'h5); send_tok(17'h10000);
        drain();

        // randomized stream with random backpressure and tile_en gaps
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                tile_en = 1'b0;
                @(negedge clk);
                check("tile_off_out_valid", 32'(data_out_valid), 32'd0);
                check("tile_off_in_ready", 32'(data_in_ready), 32'd0);
                @(posedge clk); #1;
                tile_en = 1'b1;
            end
            random_token(tok);
            send_tok(tok);
        end
        drain();
        check("done_seen_final", 32'(done_seen), 32'(model_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
